// File: rtl/sdrc_app_arb_pkg.sv
// Shared definitions for the two-master SDRAM application-port arbiter:
// FSM state encodings and the default master count.
package sdrc_app_arb_pkg;

    // Number of application masters sharing the controller port
    localparam int NUM_MASTERS = 2;

    // Arbiter FSM states; IDLE is all-zero so a reset state reads as 0
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// master that was not granted last.
module sdrc_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    // Tie resolves against the previous winner; otherwise pick whoever asks
    always_comb begin
        gnt = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/sdrc_app_arb.sv
// Arbitrates two application masters onto a single SDRAM controller request
// port and bus-width-converter data path. One burst at a time: grant in IDLE,
// present the command in CMD, then route write or read beats until the
// converter flags the last beat.
//
// Handshakes: m_req[i] is held by master i until it sees m_ack[i]; app_req is
// held in CMD until app_req_ack; a data beat transfers in any cycle where
// app_wr_next (WR) or app_rd_valid (RD) is high, and the beat carrying
// app_last_wr / app_last_rd ends the burst. There is no back-pressure from
// the masters on the data path.
module sdrc_app_arb
    import sdrc_app_arb_pkg::*;
#(
    parameter int APP_AW = 30,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int BL_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,

    // Master side
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*APP_AW-1:0] m_addr,
    input  logic [NUM_MASTERS*BL_W-1:0]   m_len,
    input  logic [NUM_MASTERS-1:0]        m_wr_n,
    output logic [NUM_MASTERS-1:0]        m_ack,
    input  logic [NUM_MASTERS*APP_DW-1:0] m_wr_data,
    input  logic [NUM_MASTERS*APP_BW-1:0] m_wr_en_n,
    output logic [NUM_MASTERS-1:0]        m_wr_next,
    output logic [APP_DW-1:0]             m_rd_data,
    output logic [NUM_MASTERS-1:0]        m_rd_valid,
    output logic [NUM_MASTERS-1:0]        m_done,

    // Controller request port
    output logic                          app_req,
    output logic [APP_AW-1:0]             app_req_addr,
    output logic [BL_W-1:0]               app_req_len,
    output logic                          app_req_wr_n,
    input  logic                          app_req_ack,

    // Bus-width converter write side
    output logic [APP_DW-1:0]             app_wr_data,
    output logic [APP_BW-1:0]             app_wr_en_n,
    input  logic                          app_wr_next,
    input  logic                          app_last_wr,

    // Bus-width converter read side
    input  logic [APP_DW-1:0]             app_rd_data,
    input  logic                          app_rd_valid,
    input  logic                          app_last_rd,

    output logic                          arb_err,
    output arb_state_e                    fsm_state
);

    arb_state_e      state;
    logic            grant;
    logic            last_grant;
    logic [BL_W-1:0] beat_cnt;
    logic [BL_W-1:0] len_q;
    logic            arb_err_q;

    logic            pick_gnt;
    logic [1:0]      grant_oh;
    logic            in_cmd;
    logic            in_wr;
    logic            in_rd;
    logic            wr_fire;
    logic            rd_fire;
    logic            burst_end;
    logic [BL_W-1:0] beat_nxt;

    logic [APP_AW-1:0] sel_addr;
    logic [BL_W-1:0]   sel_len;
    logic              sel_wr_n;

    sdrc_rr_pick u_rr_pick (
        .req  (m_req),
        .last (last_grant),
        .gnt  (pick_gnt)
    );

    // Decode state and select the granted master's request fields
    always_comb begin
        in_cmd    = (state == ST_CMD);
        in_wr     = (state == ST_WR);
        in_rd     = (state == ST_RD);
        grant_oh  = grant ? 2'b10 : 2'b01;
        sel_addr  = m_addr[int'(grant)*APP_AW +: APP_AW];
        sel_len   = m_len[int'(grant)*BL_W +: BL_W];
        sel_wr_n  = m_wr_n[grant];
        wr_fire   = in_wr & app_wr_next;
        rd_fire   = in_rd & app_rd_valid;
        burst_end = (wr_fire & app_last_wr) | (rd_fire & app_last_rd);
        beat_nxt  = beat_cnt + 1'b1;
    end

    // Route command, data and strobes to/from the granted master only
    always_comb begin
        app_req      = in_cmd;
        app_req_addr = in_cmd ? sel_addr : '0;
        app_req_len  = in_cmd ? sel_len : '0;
        app_req_wr_n = in_cmd & sel_wr_n;
        // Write data always follows the granted master; the converter only
        // samples it while it is asking for beats.
        app_wr_data  = m_wr_data[int'(grant)*APP_DW +: APP_DW];
        app_wr_en_n  = m_wr_en_n[int'(grant)*APP_BW +: APP_BW];
        m_ack        = (in_cmd & app_req_ack) ? grant_oh : 2'b00;
        m_wr_next    = wr_fire ? grant_oh : 2'b00;
        m_rd_valid   = rd_fire ? grant_oh : 2'b00;
        m_rd_data    = in_rd ? app_rd_data : '0;
        m_done       = burst_end ? grant_oh : 2'b00;
        arb_err      = arb_err_q;
        fsm_state    = state;
    end

    // Arbiter FSM: grant, command hand-off, beat counting and length check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_q      <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_req) begin
                        grant <= pick_gnt;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // The request is committed once granted; m_req is not
                    // re-examined here.
                    if (app_req_ack) begin
                        beat_cnt <= '0;
                        len_q    <= sel_len;
                        state    <= sel_wr_n ? ST_RD : ST_WR;
                    end
                end
                ST_WR, ST_RD: begin
                    if (wr_fire || rd_fire) begin
                        beat_cnt <= beat_nxt;
                    end
                    // Return to IDLE only; the next grant is decided a cycle
                    // later so masters see a 2-cycle gap after m_done.
                    if (burst_end) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                        if (beat_nxt != len_q) begin
                            arb_err_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_app_arb.sv
// Directed bench for sdrc_app_arb: single write, round-robin ties, master-1
// read, length mismatch, zero length, reset mid-burst and back-to-back gap.
module tb_sdrc_app_arb;
    import sdrc_app_arb_pkg::*;

    localparam int APP_AW = 30;
    localparam int APP_DW = 32;
    localparam int APP_BW = 4;
    localparam int BL_W   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          m_req;
    logic [2*APP_AW-1:0] m_addr;
    logic [2*BL_W-1:0]   m_len;
    logic [1:0]          m_wr_n;
    logic [1:0]          m_ack;
    logic [2*APP_DW-1:0] m_wr_data;
    logic [2*APP_BW-1:0] m_wr_en_n;
    logic [1:0]          m_wr_next;
    logic [APP_DW-1:0]   m_rd_data;
    logic [1:0]          m_rd_valid;
    logic [1:0]          m_done;
    logic                app_req;
    logic [APP_AW-1:0]   app_req_addr;
    logic [BL_W-1:0]     app_req_len;
    logic                app_req_wr_n;
    logic                app_req_ack;
    logic [APP_DW-1:0]   app_wr_data;
    logic [APP_BW-1:0]   app_wr_en_n;
    logic                app_wr_next;
    logic                app_last_wr;
    logic [APP_DW-1:0]   app_rd_data;
    logic                app_rd_valid;
    logic                app_last_rd;
    logic                arb_err;
    arb_state_e          fsm_state;

    sdrc_app_arb #(
        .APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .BL_W(BL_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_len        (m_len),
        .m_wr_n       (m_wr_n),
        .m_ack        (m_ack),
        .m_wr_data    (m_wr_data),
        .m_wr_en_n    (m_wr_en_n),
        .m_wr_next    (m_wr_next),
        .m_rd_data    (m_rd_data),
        .m_rd_valid   (m_rd_valid),
        .m_done       (m_done),
        .app_req      (app_req),
        .app_req_addr (app_req_addr),
        .app_req_len  (app_req_len),
        .app_req_wr_n (app_req_wr_n),
        .app_req_ack  (app_req_ack),
        .app_wr_data  (app_wr_data),
        .app_wr_en_n  (app_wr_en_n),
        .app_wr_next  (app_wr_next),
        .app_last_wr  (app_last_wr),
        .app_rd_data  (app_rd_data),
        .app_rd_valid (app_rd_valid),
        .app_last_rd  (app_last_rd),
        .arb_err      (arb_err),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int err_cnt = 0;
    int chk_cnt = 0;
    int wr_pulse_cnt = 0;
    logic [APP_DW-1:0] exp_q[$];
    logic [APP_AW-1:0] exp_addr [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs/outputs are handled 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_conv();
        app_req_ack  = 1'b0;
        app_wr_next  = 1'b0;
        app_last_wr  = 1'b0;
        app_rd_valid = 1'b0;
        app_last_rd  = 1'b0;
        app_rd_data  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_req   = 2'b00;
        clear_conv();
        step();
        step();
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_app_req", app_req, 1'b0);
        check("rst_addr", app_req_addr, '0);
        check("rst_m_outs", {m_ack, m_wr_next, m_rd_valid, m_done}, '0);
        check("rst_rd_data", m_rd_data, '0);
        check("rst_arb_err", arb_err, 1'b0);
        reset_n = 1'b1;
        step();
    endtask

    // Run one burst for expected master g; called in IDLE with m_req driven.
    task automatic burst(input int g, input int ack_dly, input int n_beats,
                         input bit wr, input bit drop_req);
        logic [1:0]        oh;
        logic [BL_W-1:0]   lenv;
        logic [APP_DW-1:0] d;
        logic [APP_DW-1:0] wd;
        oh   = (g == 1) ? 2'b10 : 2'b01;
        lenv = m_len[g*BL_W +: BL_W];
        check("idle_app_req", app_req, 1'b0);
        step();
        check("cmd_state", fsm_state, ST_CMD);
        check("app_req", app_req, 1'b1);
        check("req_addr", app_req_addr, exp_addr[g]);
        check("req_len", app_req_len, lenv);
        check("req_wr_n", app_req_wr_n, !wr);
        for (int i = 0; i < ack_dly; i++) begin
            check("ack_wait_m_ack", m_ack, 2'b00);
            step();
            check("ack_wait_app_req", app_req, 1'b1);
        end
        app_req_ack = 1'b1;
        #1;
        check("m_ack", m_ack, oh);
        step();
        app_req_ack = 1'b0;
        if (drop_req) m_req[g] = 1'b0;
        check("data_state", fsm_state, wr ? ST_WR : ST_RD);
        check("data_app_req", app_req, 1'b0);
        check("data_m_ack", m_ack, 2'b00);
        for (int b = 0; b < n_beats; b++) begin
            automatic bit last = (b == n_beats - 1);
            if (wr) begin
                m_wr_data   = {16'hB1B1, 16'(b), 16'hB0B0, 16'(b)};
                wd          = (g == 1) ? {16'hB1B1, 16'(b)} : {16'hB0B0, 16'(b)};
                app_wr_next = 1'b1;
                app_last_wr = last;
                #1;
                check("wr_next", m_wr_next, oh);
                if (m_wr_next[g]) wr_pulse_cnt++;
                check("wr_data", app_wr_data, wd);
                check("wr_en_n", app_wr_en_n, (g == 1) ? 4'h5 : 4'hA);
                check("wr_rd_valid", m_rd_valid, 2'b00);
            end else begin
                d            = exp_q.pop_front();
                app_rd_data  = d;
                app_rd_valid = 1'b1;
                app_last_rd  = last;
                #1;
                check("rd_valid", m_rd_valid, oh);
                check("rd_data", m_rd_data, d);
                check("rd_wr_next", m_wr_next, 2'b00);
            end
            check("done", m_done, last ? oh : 2'b00);
            step();
            clear_conv();
        end
        #1;
        check("post_done", m_done, 2'b00);
        check("post_state", fsm_state, ST_IDLE);
        check("post_outs", {m_wr_next, m_rd_valid, m_ack}, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_addr[0] = 30'h0123_4567;
        exp_addr[1] = 30'h0ABC_DEF0;
        m_addr      = {exp_addr[1], exp_addr[0]};
        m_len       = '0;
        m_wr_n      = 2'b00;
        m_wr_data   = '0;
        m_wr_en_n   = {4'h5, 4'hA};
        do_reset();

        // Single write on master 0, len 4, ack 3 cycles after app_req
        m_len = {8'd0, 8'd4};
        m_req = 2'b01;
        #1;
        check("req_same_cycle", app_req, 1'b0);
        burst(0, 3, 4, 1'b1, 1'b1);
        check("wr_pulses", wr_pulse_cnt, 4);
        check("arb_err_ok", arb_err, 1'b0);

        // Tie from reset: master 0 first, then master 1, then master 0 again
        do_reset();
        m_len = {8'd2, 8'd2};
        m_req = 2'b11;
        burst(0, 0, 2, 1'b1, 1'b1);
        burst(1, 0, 2, 1'b1, 1'b1);
        m_req = 2'b11;
        burst(0, 0, 2, 1'b1, 1'b1);
        m_req = 2'b00;
        step();

        // Read on master 1, len 2
        m_wr_n = 2'b10;
        m_len  = {8'd2, 8'd7};
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'hA5A5_0002);
        m_req = 2'b10;
        burst(1, 1, 2, 1'b0, 1'b1);
        check("rd_arb_err", arb_err, 1'b0);
        m_wr_n = 2'b00;

        // Back-to-back: master 0 keeps requesting; app_req 2 cycles after m_done
        m_len = {8'd1, 8'd1};
        m_req = 2'b01;
        burst(0, 0, 1, 1'b1, 1'b0);
        burst(0, 0, 1, 1'b1, 1'b1);

        // Length mismatch: len 4, last on beat 3; error is sticky
        m_len = {8'd0, 8'd4};
        m_req = 2'b01;
        burst(0, 0, 3, 1'b1, 1'b1);
        check("mismatch_err", arb_err, 1'b1);
        m_len = {8'd0, 8'd1};
        m_req = 2'b01;
        burst(0, 0, 1, 1'b1, 1'b1);
        check("err_sticky", arb_err, 1'b1);
        do_reset();

        // Zero length forwarded unchanged; one beat then mismatches
        m_len = {8'd0, 8'd0};
        m_req = 2'b01;
        burst(0, 0, 1, 1'b1, 1'b1);
        check("len0_err", arb_err, 1'b1);
        do_reset();

        // Reset mid-write after 2 beats: everything drops at once, no m_done
        m_len = {8'd0, 8'd4};
        m_req = 2'b01;
        step();
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        m_req       = 2'b00;
        app_wr_next = 1'b1;
        step();
        step();
        app_last_wr = 1'b1;
        #1;
        check("pre_rst_wr_next", m_wr_next, 2'b01);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_next", m_wr_next, 2'b00);
        check("mid_rst_done", m_done, 2'b00);
        check("mid_rst_state", fsm_state, ST_IDLE);
        clear_conv();
        step();
        reset_n = 1'b1;
        step();
        m_len = {8'd1, 8'd1};
        m_req = 2'b11;
        burst(0, 0, 1, 1'b1, 1'b1);
        m_req = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Bound the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d", chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
